// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, ALU codes,
// sequencer states, instruction classes and the bundle of control strobes.
// Ports: none (package).
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRX  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // The ALU decodes R-type opcodes directly; these are the extra names.
    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;
    localparam logic [4:0] ALU_INC = 5'b11111;

    // T0..T7 are encoded 0..7 so the execute step index maps onto the state.
    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_RST  = 4'd8,
        S_PCLD = 4'd9,
        S_HALT = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_MULDIV, CLS_UNARY,
        CLS_LD, CLS_LDI, CLS_ST, CLS_BRX,
        CLS_JR, CLS_JAL, CLS_IN, CLS_OUT,
        CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
    } opclass_t;

    typedef struct packed {
        logic       hi_in, lo_in, z_in, pc_in, mdr_in, mar_in, y_in, oport_in, ir_in;
        logic       hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, iport_out, c_out;
        logic       gra, grb, grc, r_in, r_out, ba_out;
        logic       con_in, mem_rd, mem_wr;
        logic [4:0] alu_code;
        logic       run;
    } ctrl_t;

endpackage

// File: rtl/ctrl_opclass_decode.sv
// Combinational opcode decode: instruction class, ALU code used in execute,
// and the index (3..7) of the final execute step.
// Ports: opcode in; op_class, alu_op, last_step out.
module ctrl_opclass_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output opclass_t   op_class,
    output logic [4:0] alu_op,
    output logic [2:0] last_step
);

    always_comb begin
        op_class  = CLS_NOP;
        alu_op    = opcode;
        last_step = 3'd3;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
                op_class  = CLS_ALU_R;
                last_step = 3'd5;
            end
            OP_ADDI: begin op_class = CLS_ALU_I; alu_op = ALU_ADD; last_step = 3'd5; end
            OP_ANDI: begin op_class = CLS_ALU_I; alu_op = ALU_AND; last_step = 3'd5; end
            OP_ORI:  begin op_class = CLS_ALU_I; alu_op = ALU_OR;  last_step = 3'd5; end
            OP_MUL, OP_DIV: begin op_class = CLS_MULDIV; last_step = 3'd6; end
            OP_NEG, OP_NOT: begin op_class = CLS_UNARY;  last_step = 3'd4; end
            OP_LD:   begin op_class = CLS_LD;   alu_op = ALU_ADD; last_step = 3'd7; end
            OP_LDI:  begin op_class = CLS_LDI;  alu_op = ALU_ADD; last_step = 3'd5; end
            OP_ST:   begin op_class = CLS_ST;   alu_op = ALU_ADD; last_step = 3'd7; end
            OP_BRX:  begin op_class = CLS_BRX;  alu_op = ALU_ADD; last_step = 3'd6; end
            OP_JR:   op_class = CLS_JR;
            OP_JAL:  begin op_class = CLS_JAL; last_step = 3'd4; end
            OP_IN:   op_class = CLS_IN;
            OP_OUT:  op_class = CLS_OUT;
            OP_MFHI: op_class = CLS_MFHI;
            OP_MFLO: op_class = CLS_MFLO;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving all DataPath strobes: fetch T0-T2, then
// an opcode-dependent execute T3..T7. Inputs: clock, clear (async, high),
// ir, ConOut. Outputs: register load/drive enables, Gra/Grb/Grc, memory
// strobes, ALUCode, run.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter bit RESET_PC_LOAD = 1'b0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        ConOut,
    output logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
    output logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
    output logic        Gra, Grb, Grc, RIn, ROut, BAOut,
    output logic        Conin,
    output logic        memread, memwrite,
    output logic [4:0]  ALUCode,
    output logic        run
);

    state_t     state_q, state_d;
    opclass_t   op_class;
    logic [4:0] alu_op;
    logic [2:0] last_step;
    ctrl_t      c;

    // Register fields are consumed by the DataPath select logic, not here.
    logic unused_ir;
    assign unused_ir = ^ir[26:0];

    ctrl_opclass_decode u_dec (
        .opcode    (ir[31:27]),
        .op_class  (op_class),
        .alu_op    (alu_op),
        .last_step (last_step)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= S_RST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = RESET_PC_LOAD ? S_PCLD : S_T0;
            S_PCLD: state_d = S_T0;
            S_T0, S_T1, S_T2: state_d = state_t'(state_q + 4'd1);
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                // ir is only valid for the new instruction from T3 onward.
                if (op_class == CLS_HALT)                         state_d = S_HALT;
                else if (state_q == state_t'({1'b0, last_step}))  state_d = S_T0;
                else                                              state_d = state_t'(state_q + 4'd1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        c     = '0;
        c.run = 1'b1;
        case (state_q)
            S_PCLD: begin c.iport_out = 1'b1; c.pc_in = 1'b1; end
            S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.alu_code = ALU_INC; c.z_in = 1'b1; end
            S_T1: begin c.zlo_out = 1'b1; c.pc_in = 1'b1; c.mem_rd = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_HALT: c.run = 1'b0;
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (op_class)
                    CLS_ALU_R, CLS_ALU_I, CLS_MULDIV: begin
                        case (state_q)
                            S_T3: begin
                                if (op_class == CLS_MULDIV) c.gra = 1'b1;
                                else                        c.grb = 1'b1;
                                c.r_out = 1'b1; c.y_in = 1'b1;
                            end
                            S_T4: begin
                                if (op_class == CLS_ALU_R)      begin c.grc = 1'b1; c.r_out = 1'b1; end
                                else if (op_class == CLS_ALU_I) c.c_out = 1'b1;
                                else                            begin c.grb = 1'b1; c.r_out = 1'b1; end
                                c.alu_code = alu_op; c.z_in = 1'b1;
                            end
                            S_T5: begin
                                c.zlo_out = 1'b1;
                                if (op_class == CLS_MULDIV) c.lo_in = 1'b1;
                                else                        begin c.gra = 1'b1; c.r_in = 1'b1; end
                            end
                            S_T6: begin c.zhi_out = 1'b1; c.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CLS_UNARY: begin
                        if (state_q == S_T3) begin
                            c.grb = 1'b1; c.r_out = 1'b1; c.alu_code = alu_op; c.z_in = 1'b1;
                        end else begin
                            c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
                        end
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        case (state_q)
                            S_T3: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
                            S_T4: begin c.c_out = 1'b1; c.alu_code = ALU_ADD; c.z_in = 1'b1; end
                            S_T5: begin
                                c.zlo_out = 1'b1;
                                if (op_class == CLS_LDI) begin c.gra = 1'b1; c.r_in = 1'b1; end
                                else                     c.mar_in = 1'b1;
                            end
                            S_T6: begin
                                c.mdr_in = 1'b1;
                                if (op_class == CLS_ST) begin c.gra = 1'b1; c.r_out = 1'b1; end
                                else                    c.mem_rd = 1'b1;
                            end
                            S_T7: begin
                                if (op_class == CLS_ST) c.mem_wr = 1'b1;
                                else begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                            end
                            default: ;
                        endcase
                    end
                    CLS_BRX: begin
                        case (state_q)
                            S_T3: begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
                            S_T4: begin c.pc_out = 1'b1; c.y_in = 1'b1; end
                            S_T5: begin c.c_out = 1'b1; c.alu_code = ALU_ADD; c.z_in = 1'b1; end
                            S_T6: if (ConOut) begin c.zlo_out = 1'b1; c.pc_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    CLS_JR:  begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
                    CLS_JAL: begin
                        // Link register is Rb: save PC first, then jump to Ra.
                        if (state_q == S_T3) begin c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1; end
                        else                 begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
                    end
                    CLS_IN:   begin c.iport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    CLS_OUT:  begin c.gra = 1'b1; c.r_out = 1'b1; c.oport_in = 1'b1; end
                    CLS_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    CLS_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn}
         = {c.hi_in, c.lo_in, c.z_in, c.pc_in, c.mdr_in, c.mar_in, c.y_in, c.oport_in, c.ir_in};
    assign {HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut}
         = {c.hi_out, c.lo_out, c.zhi_out, c.zlo_out, c.pc_out, c.mdr_out, c.iport_out, c.c_out};
    assign {Gra, Grb, Grc, RIn, ROut, BAOut} = {c.gra, c.grb, c.grc, c.r_in, c.r_out, c.ba_out};
    assign {Conin, memread, memwrite}        = {c.con_in, c.mem_rd, c.mem_wr};
    assign ALUCode = c.alu_code;
    assign run     = c.run;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic        clock, clear, ConOut;
    logic [31:0] ir;
    logic HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, run;
    logic [4:0] ALUCode;

    int total = 0;
    int bad   = 0;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .ConOut(ConOut),
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .MARIn(MARIn),
        .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn),
        .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut), .PCOut(PCOut),
        .MDROut(MDROut), .IPortOut(IPortOut), .COut(COut),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .ROut(ROut), .BAOut(BAOut),
        .Conin(Conin), .memread(memread), .memwrite(memwrite), .ALUCode(ALUCode), .run(run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // All outputs packed into one word: strobes in bits 31..6, ALUCode 5..1, run 0.
    logic [31:0] obs;
    assign obs = {HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
                  HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
                  Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, ALUCode, run};

    localparam logic [31:0] RUN = 32'h1;
    localparam logic [31:0] MEMWRITE = 32'h1 << 6,  MEMREAD = 32'h1 << 7,  CONIN = 32'h1 << 8;
    localparam logic [31:0] BAOUT = 32'h1 << 9,     ROUT = 32'h1 << 10,    RIN = 32'h1 << 11;
    localparam logic [31:0] GRC = 32'h1 << 12,      GRB = 32'h1 << 13,     GRA = 32'h1 << 14;
    localparam logic [31:0] COUT = 32'h1 << 15,     IPORTOUT = 32'h1 << 16, MDROUT = 32'h1 << 17;
    localparam logic [31:0] PCOUT = 32'h1 << 18,    ZLOOUT = 32'h1 << 19,  ZHIOUT = 32'h1 << 20;
    localparam logic [31:0] LOOUT = 32'h1 << 21,    HIOUT = 32'h1 << 22,   IRIN = 32'h1 << 23;
    localparam logic [31:0] OPORTIN = 32'h1 << 24,  YIN = 32'h1 << 25,     MARIN = 32'h1 << 26;
    localparam logic [31:0] MDRIN = 32'h1 << 27,    PCIN = 32'h1 << 28,    ZIN = 32'h1 << 29;
    localparam logic [31:0] DRIVERS = BAOUT | ROUT | COUT | IPORTOUT | MDROUT | PCOUT
                                    | ZLOOUT | ZHIOUT | LOOUT | HIOUT;

    function automatic logic [31:0] alu(input logic [4:0] code);
        return {26'b0, code, 1'b0};
    endfunction

    localparam logic [31:0] F0 = PCOUT | MARIN | ZIN | (32'h1F << 1) | RUN;
    localparam logic [31:0] F1 = ZLOOUT | PCIN | MEMREAD | MDRIN | RUN;
    localparam logic [31:0] F2 = MDROUT | IRIN | RUN;

    task automatic test_reset();
        clear = 1'b1; ir = 32'h0; ConOut = 1'b0;
        #1;
        total++;
        if (obs !== RUN) begin bad++; $display("FAIL reset_async got=%h want=%h", obs, RUN); end
        @(negedge clock);
        clear = 1'b0;
    endtask

    // Enters in RST; leaves at the T0 of the following instruction.
    task automatic test_ldi();
        logic [31:0] exp [7];
        ir = 32'h0900_0065;
        exp = '{RUN, F0, F1, F2, GRB | BAOUT | YIN | RUN,
                COUT | ZIN | alu(5'b00011) | RUN, ZLOOUT | GRA | RIN | RUN};
        foreach (exp[i]) begin
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL ldi step=%0d got=%h want=%h", i, obs, exp[i]); end
            @(negedge clock);
        end
    endtask

    task automatic test_add();
        logic [31:0] exp [6];
        ir = 32'h1A92_0000;
        exp = '{F0, F1, F2, GRB | ROUT | YIN | RUN,
                GRC | ROUT | ZIN | alu(5'b00011) | RUN, ZLOOUT | GRA | RIN | RUN};
        foreach (exp[i]) begin
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL add step=%0d got=%h want=%h", i, obs, exp[i]); end
            @(negedge clock);
        end
    endtask

    task automatic test_st_ld();
        logic [31:0] exp [16];
        logic [31:0] ir_st, ir_ld;
        ir_st = {5'b00010, 4'd1, 4'd2, 19'h00010};
        ir_ld = {5'b00000, 4'd3, 4'd2, 19'h00010};
        exp = '{F0, F1, F2, GRB | BAOUT | YIN | RUN, COUT | ZIN | alu(5'b00011) | RUN,
                ZLOOUT | MARIN | RUN, GRA | ROUT | MDRIN | RUN, MEMWRITE | RUN,
                F0, F1, F2, GRB | BAOUT | YIN | RUN, COUT | ZIN | alu(5'b00011) | RUN,
                ZLOOUT | MARIN | RUN, MEMREAD | MDRIN | RUN, MDROUT | GRA | RIN | RUN};
        foreach (exp[i]) begin
            ir = (i < 8) ? ir_st : ir_ld;
            #1;
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL st_ld step=%0d got=%h want=%h", i, obs, exp[i]); end
            total++;
            if ($countones(obs & DRIVERS) > 1 || (memread && memwrite)) begin
                bad++; $display("FAIL bus_excl step=%0d got=%h want=one_driver", i, obs);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_brx();
        logic [31:0] exp [7];
        ir = {5'b10011, 4'd3, 4'd0, 19'h00008};
        for (int k = 0; k < 2; k++) begin
            ConOut = k[0];
            exp = '{F0, F1, F2, GRA | ROUT | CONIN | RUN, PCOUT | YIN | RUN,
                    COUT | ZIN | alu(5'b00011) | RUN,
                    (k == 1) ? (ZLOOUT | PCIN | RUN) : RUN};
            foreach (exp[i]) begin
                #1;
                total++;
                if (obs !== exp[i]) begin
                    bad++; $display("FAIL brx con=%0d step=%0d got=%h want=%h", k, i, obs, exp[i]);
                end
                @(negedge clock);
            end
        end
        ConOut = 1'b0;
    endtask

    task automatic test_halt();
        logic [31:0] exp [4];
        ir = {5'b11011, 27'h0};
        exp = '{F0, F1, F2, RUN};
        foreach (exp[i]) begin
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL halt_fetch step=%0d got=%h want=%h", i, obs, exp[i]); end
            @(negedge clock);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (obs !== 32'h0) begin bad++; $display("FAIL halted idle=%0d got=%h want=%h", i, obs, 32'h0); end
            @(negedge clock);
        end
    endtask

    task automatic test_clear_mid();
        logic [31:0] exp [5];
        ir = 32'h1A92_0000;
        clear = 1'b1;
        #1;
        total++;
        if (obs !== RUN) begin bad++; $display("FAIL halt_clear got=%h want=%h", obs, RUN); end
        @(negedge clock);
        clear = 1'b0;
        exp = '{RUN, F0, F1, F2, GRB | ROUT | YIN | RUN};
        foreach (exp[i]) begin
            total++;
            if (obs !== exp[i]) begin bad++; $display("FAIL clr_add step=%0d got=%h want=%h", i, obs, exp[i]); end
            @(negedge clock);
        end
        total++;
        if (obs !== (GRC | ROUT | ZIN | alu(5'b00011) | RUN)) begin
            bad++; $display("FAIL clr_t4 got=%h want=%h", obs, GRC | ROUT | ZIN | alu(5'b00011) | RUN);
        end
        #2 clear = 1'b1;
        #1;
        total++;
        if (obs !== RUN) begin bad++; $display("FAIL clear_mid got=%h want=%h", obs, RUN); end
        @(negedge clock);
        clear = 1'b0;
        total++;
        if (obs !== RUN) begin bad++; $display("FAIL clear_held got=%h want=%h", obs, RUN); end
        @(negedge clock);
        total++;
        if (obs !== F0) begin bad++; $display("FAIL clear_restart got=%h want=%h", obs, F0); end
    endtask

    initial begin
        clear = 1'b1; ir = 32'h0; ConOut = 1'b0;
        @(negedge clock);
        test_reset();
        test_ldi();
        test_add();
        test_st_ld();
        test_brx();
        test_halt();
        test_clear_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore control sequencer for the 32-bit bus CPU.
- Drives every control strobe of the DataPath: register in/out enables, Gra/Grb/Grc selects, ALUCode, memread/memwrite and Conin.
- Sequences fetch (T0–T2) and then an opcode-dependent execute sequence (T3–T7).
- Replaces the hand-written per-cycle stimulus the datapath benches use today. It sits beside DataPath and consumes IR and ConOut.

Parameters:
- RESET_PC_LOAD, 0: 1 = spend one cycle after reset loading PC from IPortInput (IPortOut+PCIn); 0 = PC keeps its reset value.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- ir  in  32  IR contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
- ConOut  in  1  branch condition flip-flop output from DataPath.
- HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn  out  1 each  register load enables.
- HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut  out  1 each  bus drivers.
- Gra, Grb, Grc, RIn, ROut, BAOut  out  1 each  register-file select and enable.
- Conin  out  1  latch CON flip-flop.
- memread, memwrite  out  1 each  memory strobes.
- ALUCode  out  5  ALU operation.
- run  out  1  high unless halted.

Behaviour:
- States: RST, PCLD, T0..T7, HALT. Outputs are decoded only from the present state and the latched ir; ConOut is used in T6 of brx. Every strobe is held for the whole state.
- Reset: clear=1 forces state RST asynchronously. All strobes are 0, ALUCode=0, run=1. A reset mid-instruction aborts it; no memwrite may be issued after clear rises.
- RST advances to PCLD if RESET_PC_LOAD=1, else to T0.
- Fetch:
  - T0: PCOut, MARIn, ALUCode=ALU_INC (5'b11111), ZIn.
  - T1: ZLoOut, PCIn, memread, MDRIn.
  - T2: MDROut, IRIn.
- Execute, starting at T3. The last listed step returns to T0.
  - ALU R-type (add, sub, and, or, shifts, rotates): T3 Grb ROut YIn; T4 Grc ROut ALUCode=op ZIn; T5 ZLoOut Gra RIn.
  - ALU immediate (addi, andi, ori): T3 Grb ROut YIn; T4 COut ALUCode=ADD/AND/OR ZIn; T5 ZLoOut Gra RIn.
  - mul/div: T3 Gra ROut YIn; T4 Grb ROut ALUCode=op ZIn; T5 ZLoOut LoIn; T6 ZHiOut HiIn.
  - neg/not: T3 Grb ROut ALUCode=op ZIn; T4 ZLoOut Gra RIn.
  - ld: T3 Grb BAOut YIn; T4 COut ADD ZIn; T5 ZLoOut MARIn; T6 memread MDRIn; T7 MDROut Gra RIn.
  - ldi: T3–T4 as ld; T5 ZLoOut Gra RIn.
  - st: T3–T5 as ld; T6 Gra ROut MDRIn (memread=0); T7 memwrite.
  - brx: T3 Gra ROut Conin; T4 PCOut YIn; T5 COut ADD ZIn; T6 ZLoOut PCIn only if ConOut=1, else no strobes.
  - jr: T3 Gra ROut PCIn.
  - jal: T3 PCOut Grb RIn (link register in Rb); T4 Gra ROut PCIn.
  - in: T3 IPortOut Gra RIn.
  - out: T3 Gra ROut OPortIn.
  - mfhi / mflo: T3 HiOut/LoOut Gra RIn.
  - nop and undefined opcodes: T3 with no strobes, then T0.
  - halt: enter HALT. All strobes are 0, run=0. Only clear leaves HALT.
- Invariants:
  - At most one bus driver (any *Out, ROut, BAOut) is asserted per cycle.
  - memread and memwrite are never both high.

Decomposition:
- Package cpu_ctrl_pkg:
  - opcode constants (ld=00000, ldi=00001, st=00010, add=00011, sub=00100, shr..rol=00101..01001, and=01010, or=01011, addi=01100, andi=01101, ori=01110, mul=01111, div=10000, neg=10001, not=10010, brx=10011, jr=10100, jal=10101, in=10110, out=10111, mfhi=11000, mflo=11001, nop=11010, halt=11011);
  - ALUCode constants (ALU_op = opcode for R-type, ALU_INC=11111);
  - state encoding.
- One sub-module, ctrl_opclass_decode: combinational opcode → instruction class plus execute length, used by the sequencer to choose the final step.

Test Plan:
- Reset and fetch: pulse clear, then ir=32'h0900_0065 (ldi R2,0x65(R0)). RST → T0 asserts PCOut/MARIn/ZIn with ALUCode=11111; T1 memread+MDRIn+PCIn; T2 IRIn. T3 Grb+BAOut+YIn; T5 ZLoOut+Gra+RIn; then T0.
- add R5,R2,R4 (ir=32'h1A92_0000): T4 shows Grc+ROut+ZIn with ALUCode=00011; T5 Gra+RIn; 6-cycle instruction.
- st then ld: memwrite is high only in T7 of st. ld asserts memread in T6 and MDROut+Gra+RIn in T7. Check no two bus drivers are high in any cycle.
- brx with ConOut=0 vs 1: T6 PCIn=0 when ConOut=0 and PCIn=ZLoOut=1 when ConOut=1; Conin is high only in T3.
- halt (opcode 11011) then 5 idle clocks: run=0 and all strobes 0. Asserting clear mid-T4 of an add returns to RST immediately with all outputs 0 and run=1.
